fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch front end of the 4-stage pipeline: owns the PC, drives the instruction-memory address,
//   splits each 16-bit word into op[15:12]/s[11:6]/d[5:0] and registers it into the fetch->register-read buffer.
//   Folds two-word LI (opcode 4'b1111, immediate in the following word) into one issued slot.
//   Accepts stall and jump-redirect from downstream; issues bubbles on redirect.
// PARAMETERS
//   RESET_PC  16'h0000  PC value loaded on reset
//   LI_OP     4'b1111   opcode treated as two-word load-immediate
// PORTS
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   imem_addr    out  16  instruction-memory address (= PC, combinational from PC register)
//   imem_data    in   16  instruction word at imem_addr, valid same cycle
//   stall        in   1   1 = hold PC, state and all outputs
//   redirect     in   1   1 = jump taken; load redirect_pc
//   redirect_pc  in   16  jump target
//   halt         in   1   1 = stop fetching until reset
//   out_valid    out  1   output slot holds a real instruction
//   out_op       out  4   opcode
//   out_s        out  6   source register field
//   out_d        out  6   destination register field
//   out_imm      out  16  LI immediate; 16'h0000 for non-LI
//   out_li       out  1   slot is a fused LI
//   out_pc       out  16  address of the first word of the issued instruction
// BEHAVIOUR
//   Reset (async, reset==0): pc<=RESET_PC, state<=FETCH, all out_* <= 0.
//   States: FETCH, LI_IMM, HALTED. Per-edge priority: halt > redirect > stall > normal.
//   FETCH, op!=LI_OP: emit op/s/d from imem_data, out_imm<=0, out_li<=0, out_valid<=1, out_pc<=pc, pc<=pc+1.
//   FETCH, op==LI_OP: latch op/s/d and pc internally, out_valid<=0 (bubble), pc<=pc+1, ->LI_IMM.
//   LI_IMM: out_imm<=imem_data, emit latched op/s/d, out_li<=1, out_valid<=1, out_pc<=latched pc,
//     pc<=pc+1, ->FETCH. LI therefore occupies 2 cycles, issues 1 slot.
//   Latency: word at imem_addr in cycle N appears on out_* after edge N+1 (1 cycle; LI: 2 cycles from first word).
//   stall==1: pc, state, latched LI fields and every out_* hold their values; imem_data ignored.
//   redirect==1 (also when stall==1): pc<=redirect_pc, out_valid<=0, out_li<=0, state<=FETCH;
//     a half-fetched LI in LI_IMM is discarded.
//   halt==1: state<=HALTED, out_valid<=0; HALTED ignores stall/redirect; exit only by reset.
//   PC arithmetic 16-bit modulo: 16'hFFFF+1 = 16'h0000; LI at 16'hFFFF takes immediate from 16'h0000.
//   Reset asserted mid-LI: latched fields discarded, restart at RESET_PC.
//   out_* are registered only; no combinational path from stall/redirect to out_*.
// CONFIGURATION
//   FETCH_COUNT_EN defined: adds port fetch_count out 16 = number of slots issued with out_valid=1
//     (fused LI counts once), increments on the issuing edge, saturates at 16'hFFFF, cleared by reset,
//     held during stall/halt.
//   FETCH_COUNT_EN undefined: fetch_count port and counter absent; all other behaviour identical.
// TESTING
//   Reset release, imem = {0x0041,0x4083} at 0,1 -> edge1: op=0 s=1 d=1 pc=0 valid; edge2: op=4 s=2 d=3 pc=1.
//   LI: mem[5]=0xF005, mem[6]=0xBEEF, pc=5 -> bubble, then valid op=F d=5 imm=0xBEEF li=1 out_pc=5; pc=7.
//   stall held 3 cycles mid-stream -> out_* and imem_addr constant; resumes with next word, no loss/duplicate.
//   redirect to 0x0100 during LI_IMM with stall=1 -> next edge out_valid=0, imem_addr=0x0100, LI dropped.
//   pc=0xFFFF LI, mem[0]=0x1234 -> issued imm=0x1234, pc wraps to 0x0001; halt -> valid stays 0 until reset.
//   FETCH_COUNT_EN: 3 plain + 1 LI + 2 stall cycles -> fetch_count=4; reset pulse mid-run -> 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, splits op/s/d fields and fuses two-word LI into one slot.
// Optional FETCH_COUNT_EN adds a saturating issued-slot counter on fetch_count_o.
//
// state     | meaning
// ST_FETCH  | fetching a fresh instruction word
// ST_LI_IMM | first LI word latched, current word is its immediate
// ST_HALTED | fetching stopped until reset
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  LI_OP    = 4'b1111
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        out_valid_o,
    output logic [3:0]  out_op_o,
    output logic [5:0]  out_s_o,
    output logic [5:0]  out_d_o,
    output logic [15:0] out_imm_o,
    output logic        out_li_o,
    output logic [15:0] out_pc_o
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LI_IMM = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [3:0]  lat_op_q, lat_op_d;
    logic [5:0]  lat_s_q, lat_s_d;
    logic [5:0]  lat_d_q, lat_d_d;
    logic [15:0] lat_pc_q, lat_pc_d;
    logic        vld_q, vld_d;
    logic [3:0]  op_q, op_d;
    logic [5:0]  s_q, s_d;
    logic [5:0]  d_q, d_d;
    logic [15:0] imm_q, imm_d;
    logic        li_q, li_d;
    logic [15:0] opc_q, opc_d;
    logic        issue;

    logic [3:0]  w_op;
    logic [5:0]  w_s;
    logic [5:0]  w_d;

    assign w_op = imem_data_i[15:12];
    assign w_s  = imem_data_i[11:6];
    assign w_d  = imem_data_i[5:0];

    assign imem_addr_o = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lat_op_d = lat_op_q;
        lat_s_d  = lat_s_q;
        lat_d_d  = lat_d_q;
        lat_pc_d = lat_pc_q;
        vld_d    = vld_q;
        op_d     = op_q;
        s_d      = s_q;
        d_d      = d_q;
        imm_d    = imm_q;
        li_d     = li_q;
        opc_d    = opc_q;
        issue    = 1'b0;

        if (state_q == ST_HALTED) begin
            // frozen: stall and redirect have no effect here
        end else if (halt_i) begin
            state_d = ST_HALTED;
            vld_d   = 1'b0;
        end else if (redirect_i) begin
            pc_d    = redirect_pc_i;
            vld_d   = 1'b0;
            li_d    = 1'b0;
            state_d = ST_FETCH;
        end else if (!stall_i) begin
            case (state_q)
                ST_FETCH: begin
                    pc_d = pc_q + 16'd1;
                    if (w_op == LI_OP) begin
                        lat_op_d = w_op;
                        lat_s_d  = w_s;
                        lat_d_d  = w_d;
                        lat_pc_d = pc_q;
                        vld_d    = 1'b0;
                        state_d  = ST_LI_IMM;
                    end else begin
                        op_d  = w_op;
                        s_d   = w_s;
                        d_d   = w_d;
                        imm_d = 16'h0000;
                        li_d  = 1'b0;
                        vld_d = 1'b1;
                        opc_d = pc_q;
                        issue = 1'b1;
                    end
                end
                ST_LI_IMM: begin
                    op_d    = lat_op_q;
                    s_d     = lat_s_q;
                    d_d     = lat_d_q;
                    imm_d   = imem_data_i;
                    li_d    = 1'b1;
                    vld_d   = 1'b1;
                    opc_d   = lat_pc_q;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_FETCH;
                    issue   = 1'b1;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            lat_op_q <= '0;
            lat_s_q  <= '0;
            lat_d_q  <= '0;
            lat_pc_q <= '0;
            vld_q    <= 1'b0;
            op_q     <= '0;
            s_q      <= '0;
            d_q      <= '0;
            imm_q    <= '0;
            li_q     <= 1'b0;
            opc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            lat_op_q <= lat_op_d;
            lat_s_q  <= lat_s_d;
            lat_d_q  <= lat_d_d;
            lat_pc_q <= lat_pc_d;
            vld_q    <= vld_d;
            op_q     <= op_d;
            s_q      <= s_d;
            d_q      <= d_d;
            imm_q    <= imm_d;
            li_q     <= li_d;
            opc_q    <= opc_d;
        end
    end

    assign out_valid_o = vld_q;
    assign out_op_o    = op_q;
    assign out_s_o     = s_q;
    assign out_d_o     = d_q;
    assign out_imm_o   = imm_q;
    assign out_li_o    = li_q;
    assign out_pc_o    = opc_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (issue && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected issued slots against a behavioural imem.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [3:0]  out_op;
    logic [5:0]  out_s;
    logic [5:0]  out_d;
    logic [15:0] out_imm;
    logic        out_li;
    logic [15:0] out_pc;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [5:0]  s;
        logic [5:0]  d;
        logic [15:0] imm;
        logic        li;
        logic [15:0] pc;
    } slot_t;

    slot_t sb[$];
    logic [15:0] mem [0:65535];
    int errors = 0;
    int checks = 0;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .halt_i       (halt),
        .out_valid_o  (out_valid),
        .out_op_o     (out_op),
        .out_s_o      (out_s),
        .out_d_o      (out_d),
        .out_imm_o    (out_imm),
        .out_li_o     (out_li),
        .out_pc_o     (out_pc)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count_o(fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [15:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== target) begin
            errors++;
            $display("FAIL redirect_setup: valid=%b addr=%h, required valid=0 addr=%h", out_valid, imem_addr, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        #12;
        checks++;
        if ({out_valid, out_op, out_s, out_d, out_imm, out_li, out_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required all zero",
                     {out_valid, out_op, out_s, out_d, out_imm, out_li, out_pc});
        end
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc: got %h, required 0000", imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_plain();
        slot_t exp, got;
        sb.push_back('{4'h0, 6'd1, 6'd1, 16'h0, 1'b0, 16'h0000});
        sb.push_back('{4'h4, 6'd2, 6'd3, 16'h0, 1'b0, 16'h0001});
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = sb.pop_front();
            got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
            checks++;
            if (out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL plain_slot%0d: valid=%b got %h, required valid=1 %h", i, out_valid, got, exp);
            end
        end
    endtask

    task automatic test_li();
        slot_t exp, got;
        mem[5] = 16'hF005; mem[6] = 16'hBEEF; mem[7] = 16'h1042;
        jump_to(16'h0005);
        sb.push_back('{4'hF, 6'd0, 6'd5, 16'hBEEF, 1'b1, 16'h0005});
        sb.push_back('{4'h1, 6'd1, 6'd2, 16'h0000, 1'b0, 16'h0007});
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0006) begin
            errors++;
            $display("FAIL li_bubble: valid=%b addr=%h, required valid=0 addr=0006", out_valid, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = sb.pop_front();
            got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
            checks++;
            if (out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL li_slot%0d: valid=%b got %h, required valid=1 %h", i, out_valid, got, exp);
            end
        end
        checks++;
        if (imem_addr !== 16'h0008) begin
            errors++;
            $display("FAIL li_pc: got %h, required 0008", imem_addr);
        end
    endtask

    task automatic test_stall();
        slot_t exp, got, last;
        last = '0;
        for (int i = 0; i < 6; i++) begin
            mem[16'h0020 + 16'(i)] = {4'(i + 1), 6'(i + 8), 6'(2 * i)};
            sb.push_back('{4'(i + 1), 6'(i + 8), 6'(2 * i), 16'h0, 1'b0, 16'(32'h20 + i)});
        end
        jump_to(16'h0020);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                stall = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
                    checks++;
                    if (out_valid !== 1'b1 || got !== last || imem_addr !== 16'h0022) begin
                        errors++;
                        $display("FAIL stall_hold%0d: valid=%b got %h addr=%h, required valid=1 %h addr=0022",
                                 k, out_valid, got, imem_addr, last);
                    end
                end
                stall = 1'b0;
            end
            tick();
            exp = sb.pop_front();
            got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
            checks++;
            if (out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL stall_stream%0d: valid=%b got %h, required valid=1 %h", i, out_valid, got, exp);
            end
            last = exp;
        end
    endtask

    task automatic test_redirect_li();
        slot_t exp, got;
        mem[16'h0040] = 16'hF123; mem[16'h0041] = 16'hAAAA;
        mem[16'h0100] = 16'h2081;
        jump_to(16'h0040);
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0041) begin
            errors++;
            $display("FAIL redir_li_bubble: valid=%b addr=%h, required valid=0 addr=0041", out_valid, imem_addr);
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        stall = 1'b0; redirect = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_li !== 1'b0 || imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL redir_during_li: valid=%b li=%b addr=%h, required valid=0 li=0 addr=0100",
                     out_valid, out_li, imem_addr);
        end
        sb.push_back('{4'h2, 6'd2, 6'd1, 16'h0000, 1'b0, 16'h0100});
        tick();
        exp = sb.pop_front();
        got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL redir_target: valid=%b got %h, required valid=1 %h", out_valid, got, exp);
        end
    endtask

    task automatic test_wrap();
        slot_t exp, got;
        mem[16'hFFFF] = 16'hF0C7; mem[16'h0000] = 16'h1234; mem[16'h0001] = 16'h3000;
        jump_to(16'hFFFF);
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_bubble: valid=%b addr=%h, required valid=0 addr=0000", out_valid, imem_addr);
        end
        sb.push_back('{4'hF, 6'd3, 6'd7, 16'h1234, 1'b1, 16'hFFFF});
        tick();
        exp = sb.pop_front();
        got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
        checks++;
        if (out_valid !== 1'b1 || got !== exp || imem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_li: valid=%b got %h addr=%h, required valid=1 %h addr=0001",
                     out_valid, got, imem_addr, exp);
        end
    endtask

    task automatic test_halt();
        slot_t exp, got;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b0 || imem_addr !== 16'h0001) begin
                errors++;
                $display("FAIL halt_hold%0d: valid=%b addr=%h, required valid=0 addr=0001", k, out_valid, imem_addr);
            end
            stall = k[0]; redirect = ~k[0]; redirect_pc = 16'h0055;
            tick();
        end
        stall = 1'b0; redirect = 1'b0;
        mem[0] = 16'h0041;
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL halt_reset: valid=%b addr=%h, required valid=0 addr=0000", out_valid, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{4'h0, 6'd1, 6'd1, 16'h0, 1'b0, 16'h0000});
        tick();
        exp = sb.pop_front();
        got = '{out_op, out_s, out_d, out_imm, out_li, out_pc};
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL halt_restart: valid=%b got %h, required valid=1 %h", out_valid, got, exp);
        end
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_fetch_count();
        rst_n = 1'b0;
        mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003;
        mem[3] = 16'hF00A; mem[4] = 16'h5555;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL count_plain: got %0d, required 3", fetch_count);
        end
        tick();
        tick();
        stall = 1'b1;
        tick();
        tick();
        checks++;
        if (fetch_count !== 16'd4) begin
            errors++;
            $display("FAIL count_li_stall: got %0d, required 4", fetch_count);
        end
        stall = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (fetch_count !== 16'd0) begin
            errors++;
            $display("FAIL count_reset: got %0d, required 0", fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[0] = 16'h0041;
        mem[1] = 16'h4083;
        test_reset();
        test_plain();
        test_li();
        test_stall();
        test_redirect_li();
        test_wrap();
        test_halt();
`ifdef FETCH_COUNT_EN
        test_fetch_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
